// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: converts a first-quadrant (X, Y) vector to angle and magnitude.
// Angle units: 256 = 90 degrees; one micro-rotation per clock.
module cordic_vectoring #(
  parameter int WIDTH    = 8,
  parameter int ITER     = 8,
  parameter int GAIN_INV = 155
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] X_IN,
  input  logic [WIDTH-1:0] Y_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ANGLE,
  output logic [WIDTH:0]   MAG
);

  localparam int XW = WIDTH + 4;
  localparam int ZW = 10;
  localparam int PW = XW + 10;
  localparam logic signed [ZW-1:0] ZMAX = ZW'(2**WIDTH - 1);
  localparam logic [2:0] ILAST = 3'(ITER - 1);
  localparam logic signed [ZW-1:0] ATAN [8] = '{
    10'sd128, 10'sd76, 10'sd40, 10'sd20, 10'sd10, 10'sd5, 10'sd3, 10'sd1
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROTATE,
    S_SCALE,
    S_DONE
  } state_t;

  state_t state_q;
  logic signed [XW-1:0] x_q, y_q, x_d, y_d, xShift, yShift;
  logic signed [ZW-1:0] z_q, z_d, zStep;
  logic signed [PW-1:0] prod;
  logic [2:0]       i_q;
  logic             zero_q, busy_q, done_q;
  logic [WIDTH-1:0] angle_q, angle_d;
  logic [WIDTH:0]   mag_q, mag_d;

  // The sign of y picks the rotation direction that drives y toward zero.
  always_comb begin
    xShift = x_q >>> i_q;
    yShift = y_q >>> i_q;
    zStep  = ATAN[i_q];
    if (!y_q[XW-1]) begin
      x_d = x_q + yShift;
      y_d = y_q - xShift;
      z_d = z_q + zStep;
    end else begin
      x_d = x_q - yShift;
      y_d = y_q + xShift;
      z_d = z_q - zStep;
    end
  end

  // Gain compensation and clamping of the accumulated angle into the output range.
  always_comb begin
    prod    = PW'(x_q) * PW'(GAIN_INV);
    mag_d   = (WIDTH+1)'(prod >>> 8);
    angle_d = WIDTH'(z_q);
    if (z_q < 0) begin
      angle_d = '0;
    end else if (z_q > ZMAX) begin
      angle_d = '1;
    end
  end

  // A zero vector keeps x, y, z at zero so the angle does not drift to the table sum.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            x_q     <= XW'(X_IN);
            y_q     <= XW'(Y_IN);
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= (X_IN == '0) && (Y_IN == '0);
            busy_q  <= 1'b1;
            state_q <= S_ROTATE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ROTATE: begin
          if (!zero_q) begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
          end
          i_q <= i_q + 3'd1;
          if (i_q == ILAST) begin
            state_q <= S_SCALE;
          end
        end
        S_SCALE: begin
          mag_q   <= mag_d;
          angle_q <= angle_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ANGLE = angle_q;
  assign MAG   = mag_q;

endmodule
